bus_bridge: RTL and testbench

BUS_BRIDGE -- requirements
Module: bus_bridge

---
 rtl/bus_bridge_pkg.sv | 22 ++
 rtl/bus_bridge_if.sv | 37 +++
 rtl/bus_bridge_timer.sv | 36 +++
 rtl/bus_bridge.sv | 124 ++++++++++++
 tb/tb_bus_bridge.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_bridge_pkg.sv
// Shared definitions for the bus bridge: FSM state encoding, default
// parameter values and the slave-select field width helper.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } state_t;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_N_SLV   = 4;
    localparam int DEF_SEL_LSB = 28;
    localparam int DEF_TIMEOUT = 15;

    function automatic int sel_width(input int nSlv);
        return (nSlv <= 2) ? 1 : $clog2(nSlv);
    endfunction

endpackage

// File: rtl/bus_bridge_if.sv
// CPU-side and slave-side signals of the bridge. The bridge connects through
// the slave modport; the CPU and slave models connect through master.
interface bus_bridge_if
    import bus_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int N_SLV  = DEF_N_SLV
);
    logic                    cpu_req;
    logic                    cpu_w;
    logic [ADDR_W-1:0]       cpu_addr;
    logic [DATA_W-1:0]       cpu_wdata;
    logic [DATA_W-1:0]       cpu_rdata;
    logic                    cpu_ready;
    logic                    cpu_err;
    logic [N_SLV-1:0]        slv_sel;
    logic                    slv_w;
    logic [ADDR_W-1:0]       slv_addr;
    logic [DATA_W-1:0]       slv_wdata;
    logic [N_SLV*DATA_W-1:0] slv_rdata;
    logic [N_SLV-1:0]        slv_ack;
    logic [ADDR_W-1:0]       err_addr;

    modport slave (
        input  cpu_req, cpu_w, cpu_addr, cpu_wdata, slv_rdata, slv_ack,
        output cpu_rdata, cpu_ready, cpu_err, slv_sel, slv_w, slv_addr,
               slv_wdata, err_addr
    );

    modport master (
        output cpu_req, cpu_w, cpu_addr, cpu_wdata, slv_rdata, slv_ack,
        input  cpu_rdata, cpu_ready, cpu_err, slv_sel, slv_w, slv_addr,
               slv_wdata, err_addr
    );

endinterface

// File: rtl/bus_bridge_timer.sv
// ACCESS-phase cycle counter with synchronous clear, enable and an expiry
// flag that is raised while the count sits at TIMEOUT-1.
module bus_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_bridge.sv
// Single-master bridge: decodes a slave slot from the CPU address, runs one
// access with a timeout, and returns a one-cycle ready/error response.
module bus_bridge
    import bus_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int N_SLV   = DEF_N_SLV,
    parameter int SEL_LSB = DEF_SEL_LSB,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    bus_bridge_if.slave  bus
);
    localparam int SEL_W = sel_width(N_SLV);
    localparam logic [N_SLV-1:0] SEL_ONE = {{(N_SLV-1){1'b0}}, 1'b1};

    state_t              state_q;
    logic [SEL_W-1:0]    slot_q;
    logic [DATA_W-1:0]   cpuRdata_q;
    logic                cpuReady_q;
    logic                cpuErr_q;
    logic [N_SLV-1:0]    slvSel_q;
    logic                slvW_q;
    logic [ADDR_W-1:0]   slvAddr_q;
    logic [DATA_W-1:0]   slvWdata_q;
    logic [ADDR_W-1:0]   errAddr_q;

    logic [SEL_W-1:0]    slotIn;
    logic                slotValid;
    logic                ackHit;
    logic [DATA_W-1:0]   rdSel;
    logic                expired;

    assign slotIn    = bus.cpu_addr[SEL_LSB +: SEL_W];
    assign slotValid = ({1'b0, slotIn} < (SEL_W + 1)'(N_SLV));
    assign ackHit    = bus.slv_ack[slot_q];
    assign rdSel     = bus.slv_rdata[int'(slot_q) * DATA_W +: DATA_W];

    bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (state_q != ACCESS),
        .en_i      (state_q == ACCESS),
        .expired_o (expired)
    );

    // Ack is tested before expiry so a last-cycle ack still completes normally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            cpuRdata_q <= '0;
            cpuReady_q <= 1'b0;
            cpuErr_q   <= 1'b0;
            slvSel_q   <= '0;
            slvW_q     <= 1'b0;
            slvAddr_q  <= '0;
            slvWdata_q <= '0;
            errAddr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cpuReady_q <= 1'b0;
                    cpuErr_q   <= 1'b0;
                    cpuRdata_q <= '0;
                    if (bus.cpu_req) begin
                        slvAddr_q  <= bus.cpu_addr;
                        slvWdata_q <= bus.cpu_wdata;
                        slot_q     <= slotIn;
                        if (slotValid) begin
                            state_q  <= ACCESS;
                            slvSel_q <= SEL_ONE << slotIn;
                            slvW_q   <= bus.cpu_w;
                        end else begin
                            state_q    <= ERR;
                            cpuReady_q <= 1'b1;
                            cpuErr_q   <= 1'b1;
                            errAddr_q  <= bus.cpu_addr;
                        end
                    end
                end
                ACCESS: begin
                    if (ackHit) begin
                        state_q    <= RESP;
                        cpuReady_q <= 1'b1;
                        cpuRdata_q <= slvW_q ? '0 : rdSel;
                        slvSel_q   <= '0;
                        slvW_q     <= 1'b0;
                    end else if (expired) begin
                        state_q    <= ERR;
                        cpuReady_q <= 1'b1;
                        cpuErr_q   <= 1'b1;
                        slvSel_q   <= '0;
                        slvW_q     <= 1'b0;
                        errAddr_q  <= slvAddr_q;
                    end
                end
                RESP, ERR: begin
                    state_q    <= IDLE;
                    cpuReady_q <= 1'b0;
                    cpuErr_q   <= 1'b0;
                    cpuRdata_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_rdata = cpuRdata_q;
    assign bus.cpu_ready = cpuReady_q;
    assign bus.cpu_err   = cpuErr_q;
    assign bus.slv_sel   = slvSel_q;
    assign bus.slv_w     = slvW_q;
    assign bus.slv_addr  = slvAddr_q;
    assign bus.slv_wdata = slvWdata_q;
    assign bus.err_addr  = errAddr_q;

endmodule

// File: tb/tb_bus_bridge.sv
// Bench for bus_bridge: a 4-slot instance for directed vectors and random
// traffic, plus a 3-slot instance for the unmapped-slot error path.
module tb_bus_bridge;

    localparam int TO = 15;

    logic clk;
    logic rst;

    int nCompared;
    int nMismatched;
    logic [31:0] modelErrAddr;

    bus_bridge_if #(.DATA_W(32), .ADDR_W(32), .N_SLV(4)) bus4 ();
    bus_bridge_if #(.DATA_W(32), .ADDR_W(32), .N_SLV(3)) bus3 ();

    bus_bridge #(
        .DATA_W(32), .ADDR_W(32), .N_SLV(4), .SEL_LSB(28), .TIMEOUT(TO)
    ) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    bus_bridge #(
        .DATA_W(32), .ADDR_W(32), .N_SLV(3), .SEL_LSB(28), .TIMEOUT(TO)
    ) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ackCycle;
        logic [3:0]  noise;
        logic [31:0] expRdata;
        logic        expErr;
        int          expLat;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level expectation: ack in ACCESS cycle k gives ready in k+1,
    // no ack gives an error after TO access cycles; writes return zero data.
    function automatic void predict(input logic w, input int ackCycle, input logic [31:0] rdata,
                                    output logic [31:0] expRdata, output logic expErr,
                                    output int expLat);
        expErr   = (ackCycle < 1 || ackCycle > TO);
        expLat   = expErr ? TO + 1 : ackCycle + 1;
        expRdata = (expErr || w) ? 32'h0 : rdata;
    endfunction

    // Starts at a falling edge with the bridge idle; ends one cycle after ready.
    task automatic applyStimulus(input string tag, input logic w, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int ackCycle, input logic [3:0] noise,
                                 input logic [31:0] expRdata, input logic expErr,
                                 input int expLat);
        logic [1:0] slot;
        logic [3:0] oneHot;
        int lat;
        int selCycles;
        logic selOk;
        slot   = addr[29:28];
        oneHot = 4'b0001 << slot;
        bus4.cpu_req   = 1'b1;
        bus4.cpu_w     = w;
        bus4.cpu_addr  = addr;
        bus4.cpu_wdata = wdata;
        for (int i = 0; i < 4; i++) begin
            bus4.slv_rdata[i*32 +: 32] = (i == int'(slot)) ? rdata : $urandom;
        end
        bus4.slv_ack = noise & ~oneHot;
        @(negedge clk);
        bus4.cpu_req   = 1'b0;
        bus4.cpu_w     = ~w;
        bus4.cpu_addr  = $urandom;
        bus4.cpu_wdata = $urandom;
        lat       = 0;
        selCycles = 0;
        selOk     = 1'b1;
        for (int c = 1; c <= TO + 4; c++) begin
            if (bus4.cpu_ready === 1'b1) begin
                lat = c;
                break;
            end
            if (bus4.slv_sel !== oneHot || bus4.slv_w !== w ||
                bus4.slv_addr !== addr || bus4.slv_wdata !== wdata) begin
                selOk = 1'b0;
            end
            selCycles++;
            bus4.slv_ack = (noise & ~oneHot) | ((c == ackCycle) ? oneHot : 4'b0000);
            @(negedge clk);
        end
        bus4.slv_ack = 4'b0000;
        checkOutput({tag, ".latency"}, 64'(lat), 64'(expLat));
        checkOutput({tag, ".accessBus"}, {63'h0, selOk}, 64'h1);
        checkOutput({tag, ".selCycles"}, 64'(selCycles), 64'(expLat - 1));
        if (lat != 0) begin
            checkOutput({tag, ".err"}, {63'h0, bus4.cpu_err}, {63'h0, expErr});
            checkOutput({tag, ".rdata"}, {32'h0, bus4.cpu_rdata}, {32'h0, expRdata});
            checkOutput({tag, ".selIdle"}, {60'h0, bus4.slv_sel}, 64'h0);
        end
        if (expErr) modelErrAddr = addr;
        @(negedge clk);
        checkOutput({tag, ".pulse"}, {63'h0, bus4.cpu_ready}, 64'h0);
        checkOutput({tag, ".errAddr"}, {32'h0, bus4.err_addr}, {32'h0, modelErrAddr});
    endtask

    initial begin
        logic        rw;
        logic [31:0] ra, rwd, rrd, er;
        logic [3:0]  rn;
        logic        ee;
        int          ak, el;

        nCompared    = 0;
        nMismatched  = 0;
        modelErrAddr = 32'h0;

        bus4.cpu_req = 1'b0; bus4.cpu_w = 1'b0; bus4.cpu_addr = '0; bus4.cpu_wdata = '0;
        bus4.slv_rdata = '0; bus4.slv_ack = '0;
        bus3.cpu_req = 1'b0; bus3.cpu_w = 1'b0; bus3.cpu_addr = '0; bus3.cpu_wdata = '0;
        bus3.slv_rdata = '0; bus3.slv_ack = '0;

        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        checkOutput("reset.ready", {63'h0, bus4.cpu_ready}, 64'h0);
        checkOutput("reset.err", {63'h0, bus4.cpu_err}, 64'h0);
        checkOutput("reset.rdata", {32'h0, bus4.cpu_rdata}, 64'h0);
        checkOutput("reset.sel", {60'h0, bus4.slv_sel}, 64'h0);
        checkOutput("reset.slvBus", {bus4.slv_addr, bus4.slv_wdata}, 64'h0);
        checkOutput("reset.errAddr", {31'h0, bus4.slv_w, bus4.err_addr}, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        vecs[0] = '{1'b0, 32'h2000_0010, 32'h0000_0000, 32'hDEAD_BEEF,  3, 4'b0000, 32'hDEAD_BEEF, 1'b0,  4};
        vecs[1] = '{1'b1, 32'h1000_0004, 32'h1234_5678, 32'h7777_7777,  1, 4'b0000, 32'h0000_0000, 1'b0,  2};
        vecs[2] = '{1'b0, 32'h3000_0100, 32'h0000_0000, 32'h1111_2222,  0, 4'b0000, 32'h0000_0000, 1'b1, 16};
        vecs[3] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 32'hCAFE_F00D, 15, 4'b0000, 32'hCAFE_F00D, 1'b0, 16};
        vecs[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'hAAAA_5555,  0, 4'b0010, 32'h0000_0000, 1'b1, 16};
        vecs[5] = '{1'b1, 32'h3000_0008, 32'h0BAD_F00D, 32'hFFFF_FFFF,  2, 4'b0000, 32'h0000_0000, 1'b0,  3};
        vecs[6] = '{1'b0, 32'h1ABC_DEF0, 32'h0000_0000, 32'h0000_0001,  1, 4'b1101, 32'h0000_0001, 1'b0,  2};
        vecs[7] = '{1'b1, 32'hE000_0FFC, 32'h5555_AAAA, 32'h0000_0000, 14, 4'b1011, 32'h0000_0000, 1'b0, 15};

        for (int v = 0; v < 8; v++) begin
            applyStimulus($sformatf("vec%0d", v), vecs[v].w, vecs[v].addr, vecs[v].wdata,
                          vecs[v].rdata, vecs[v].ackCycle, vecs[v].noise,
                          vecs[v].expRdata, vecs[v].expErr, vecs[v].expLat);
        end

        // Reset asserted in the second access cycle must abort without ready.
        bus4.cpu_req  = 1'b1;
        bus4.cpu_w    = 1'b0;
        bus4.cpu_addr = 32'h2000_0020;
        @(negedge clk);
        bus4.cpu_req = 1'b0;
        @(negedge clk);
        checkOutput("abort.selBefore", {60'h0, bus4.slv_sel}, 64'h4);
        rst = 1'b0;
        #1;
        checkOutput("abort.sel", {60'h0, bus4.slv_sel}, 64'h0);
        checkOutput("abort.ctrl", {61'h0, bus4.slv_w, bus4.cpu_ready, bus4.cpu_err}, 64'h0);
        checkOutput("abort.slvBus", {bus4.slv_addr, bus4.slv_wdata}, 64'h0);
        checkOutput("abort.errAddr", {bus4.cpu_rdata, bus4.err_addr}, 64'h0);
        modelErrAddr = 32'h0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("abort.noReady", {63'h0, bus4.cpu_ready}, 64'h0);
        end
        rst = 1'b1;
        @(negedge clk);
        applyStimulus("afterReset", 1'b0, 32'h2000_0030, 32'h0, 32'h600D_0001, 2, 4'b0000,
                      32'h600D_0001, 1'b0, 3);

        // Unmapped slot on the 3-slave instance errors straight from IDLE.
        bus3.cpu_req  = 1'b1;
        bus3.cpu_w    = 1'b0;
        bus3.cpu_addr = 32'h3000_0000;
        @(negedge clk);
        bus3.cpu_req = 1'b0;
        checkOutput("n3.readyErr", {62'h0, bus3.cpu_ready, bus3.cpu_err}, 64'h3);
        checkOutput("n3.sel", {61'h0, bus3.slv_sel}, 64'h0);
        checkOutput("n3.rdata", {32'h0, bus3.cpu_rdata}, 64'h0);
        checkOutput("n3.errAddr", {32'h0, bus3.err_addr}, 64'h3000_0000);
        @(negedge clk);
        checkOutput("n3.pulse", {63'h0, bus3.cpu_ready}, 64'h0);
        bus3.cpu_req  = 1'b1;
        bus3.cpu_addr = 32'h2000_0008;
        bus3.slv_rdata = {32'h5A5A_0003, 32'h1111_1111, 32'h2222_2222};
        @(negedge clk);
        bus3.cpu_req = 1'b0;
        checkOutput("n3.selSlot2", {61'h0, bus3.slv_sel}, 64'h4);
        bus3.slv_ack = 3'b100;
        @(negedge clk);
        bus3.slv_ack = 3'b000;
        checkOutput("n3.readResp", {30'h0, bus3.cpu_ready, bus3.cpu_err, bus3.cpu_rdata}, 64'h2_5A5A_0003);
        @(negedge clk);
        checkOutput("n3.errSticky", {32'h0, bus3.err_addr}, 64'h3000_0000);

        for (int t = 0; t < 40; t++) begin
            rw  = 1'($urandom);
            ra  = $urandom;
            rwd = $urandom;
            rrd = $urandom;
            rn  = 4'($urandom);
            ak  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TO));
            predict(rw, ak, rrd, er, ee, el);
            applyStimulus($sformatf("rnd%0d", t), rw, ra, rwd, rrd, ak, rn, er, ee, el);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
